ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as LED set or reset, from the terminal to the keyboard over the open-drain PS/2 clock and data lines. It is the counterpart of the PS/2 receiver and shares the same two physical lines, driving them only through drive-low enables. During a transfer `tx_busy` is high; the top level uses it to suppress receiver output.

---
 rtl/ps2_tx.sv | 169 ++++++++++++++++
 tb/tb_ps2_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts one byte out on device clock edges and checks the device ack.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int SETUP_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int DLY_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DLY_W-1:0] INHIBIT_LAST = DLY_W'(INHIBIT_CYCLES - 1);
  localparam logic [DLY_W-1:0] SETUP_LAST   = DLY_W'(SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t           state, state_n;
  logic             clk_s1, clk_s2, data_s1, data_s2;
  logic [3:0]       clk_hist;
  logic             fall;
  logic [7:0]       shreg, shreg_n;
  logic             parity, parity_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [DLY_W-1:0] dly_cnt, dly_cnt_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic             data_bit, data_bit_n;
  logic             done_q, done_n;
  logic             error_q, error_n;

  // Lines idle high, so synchronizers and history reset to 1 to avoid a false edge.
  always_ff @(posedge clk100) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_hist <= 4'hF;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
      clk_hist <= {clk_hist[2:0], clk_s2};
    end
  end

  assign fall = (clk_hist == 4'b1100);

  always_ff @(posedge clk100) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      parity   <= 1'b0;
      bit_cnt  <= '0;
      dly_cnt  <= '0;
      to_cnt   <= '0;
      data_bit <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      parity   <= parity_n;
      bit_cnt  <= bit_cnt_n;
      dly_cnt  <= dly_cnt_n;
      to_cnt   <= to_cnt_n;
      data_bit <= data_bit_n;
      done_q   <= done_n;
      error_q  <= error_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    parity_n   = parity;
    bit_cnt_n  = bit_cnt;
    dly_cnt_n  = dly_cnt;
    to_cnt_n   = to_cnt;
    data_bit_n = data_bit;
    done_n     = 1'b0;
    error_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_start && !done_q && !error_q) begin
          shreg_n   = tx_data;
          parity_n  = ~^tx_data;
          dly_cnt_n = '0;
          state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (dly_cnt == INHIBIT_LAST) begin
          dly_cnt_n = '0;
          state_n   = S_REQ;
        end else begin
          dly_cnt_n = dly_cnt + 1'b1;
        end
      end
      S_REQ: begin
        if (dly_cnt == SETUP_LAST) begin
          to_cnt_n   = '0;
          bit_cnt_n  = '0;
          data_bit_n = 1'b1;
          state_n    = S_WAIT;
        end else begin
          dly_cnt_n = dly_cnt + 1'b1;
        end
      end
      // Timeout is checked first so an edge landing on the expiry cycle is dropped.
      S_WAIT, S_RELEASE: begin
        if (to_cnt == TIMEOUT_LAST) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
          if (state == S_RELEASE) begin
            if (clk_s2 && data_s2) begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end
          end else if (fall) begin
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              data_bit_n = ~shreg[0];
              shreg_n    = {1'b0, shreg[7:1]};
            end else if (bit_cnt == 4'd8) begin
              data_bit_n = ~parity;
            end else if (bit_cnt == 4'd9) begin
              data_bit_n = 1'b0;
            end else if (!data_s2) begin
              state_n = S_RELEASE;
            end else begin
              error_n = 1'b1;
              state_n = S_IDLE;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign ps2_clk_low  = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2_data_low = (state == S_REQ) || ((state == S_WAIT) && data_bit);
  assign tx_busy      = (state != S_IDLE);
  assign tx_done      = done_q;
  assign tx_error     = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: an open-drain device model on the lines, a timestamp-based
// reference model compared every cycle, and literal frame/timing expectations.
module tb_ps2_tx;

  localparam int I    = 20;
  localparam int S    = 4;
  localparam int T    = 1000;
  localparam int HALF = 20;

  logic       clk100 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_low, ps2_data_low, tx_busy, tx_done, tx_error;

  int          checks = 0;
  int          passes = 0;
  bit          chk_en = 1'b0;
  logic [10:0] cap_bits;

  // Reference model state: expected outputs {clk_low, data_low, busy, done, error}.
  logic [4:0] exp_out = 5'b0;
  logic [7:0] pc_h = 8'hFF;
  logic [7:0] pd_h = 8'hFF;
  bit         m_active = 1'b0, m_released = 1'b0, m_wait_dl = 1'b0, m_par = 1'b0;
  bit         m_done = 1'b0, m_error = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_ts = 0, m_edges = 0, cyc = 0;

  assign ps2_clk  = ~(ps2_clk_low | dev_clk_low);
  assign ps2_data = ~(ps2_data_low | dev_data_low);

  always #5 clk100 = ~clk100;

  ps2_tx #(
    .INHIBIT_CYCLES(I),
    .SETUP_CYCLES(S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk100(clk100),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ps2_clk_low(ps2_clk_low),
    .ps2_data_low(ps2_data_low),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  // Runs at each negedge: compare this cycle, then predict the next one from
  // this cycle's inputs using start timestamps and the pin-sample history.
  task automatic model_step();
    int nxt, rel, w;
    bit prev_pulse, fall;
    if (chk_en) begin
      checks++;
      if ({ps2_clk_low, ps2_data_low, tx_busy, tx_done, tx_error} === exp_out) passes++;
      else $display("[TB] FAIL cycle_model @%0d: got %b, required %b", cyc,
                    {ps2_clk_low, ps2_data_low, tx_busy, tx_done, tx_error}, exp_out);
    end
    pc_h = {pc_h[6:0], ps2_clk};
    pd_h = {pd_h[6:0], ps2_data};
    prev_pulse = m_done | m_error;
    m_done  = 1'b0;
    m_error = 1'b0;
    nxt = cyc + 1;
    if (rst) begin
      m_active = 1'b0;
      pc_h = 8'hFF;
      pd_h = 8'hFF;
    end else if (!m_active) begin
      if (tx_start && !prev_pulse) begin
        m_active   = 1'b1;
        m_ts       = nxt;
        m_byte     = tx_data;
        m_par      = ~^tx_data;
        m_edges    = 0;
        m_wait_dl  = 1'b1;
        m_released = 1'b0;
      end
    end else begin
      rel = nxt - m_ts;
      if (rel > I + S) begin
        w = rel - (I + S);
        fall = pc_h[6] && pc_h[5] && !pc_h[4] && !pc_h[3];
        if (w == T) begin
          m_active = 1'b0;
          m_error  = 1'b1;
        end else if (m_released) begin
          if (pc_h[2] && pd_h[2]) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end else if (fall) begin
          m_edges++;
          if (m_edges <= 8) m_wait_dl = ~m_byte[m_edges-1];
          else if (m_edges == 9) m_wait_dl = ~m_par;
          else if (m_edges == 10) m_wait_dl = 1'b0;
          else if (!pd_h[2]) m_released = 1'b1;
          else begin
            m_active = 1'b0;
            m_error  = 1'b1;
          end
        end
      end
    end
    cyc = nxt;
    rel = cyc - m_ts;
    if (!m_active) exp_out = {3'b000, m_done, m_error};
    else if (rel < I) exp_out = 5'b10100;
    else if (rel < I + S) exp_out = 5'b11100;
    else exp_out = {1'b0, (!m_released && m_wait_dl), 1'b1, 2'b00};
  endtask

  // Pulses tx_start and pins the request timing; returns in the first WAIT cycle.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    tick();
    tx_data  = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_data  = ~b;
    checkOutput("busy_at_cycle1", int'(tx_busy), 1);
    checkOutput("clk_low_at_cycle1", int'(ps2_clk_low), 1);
    n = 1;
    while (!ps2_data_low && n < 1 + I + 50) begin
      tick();
      n++;
    end
    checkOutput("data_low_rise_cycle", n, 1 + I);
    while (ps2_clk_low && n < 1 + I + S + 50) begin
      tick();
      n++;
    end
    checkOutput("clk_release_cycle", n, 1 + I + S);
  endtask

  task automatic device_frame(input int n_edges, input bit ack, input bit meas);
    int guard, k;
    guard = 0;
    while (!(ps2_clk_low == 1'b0 && ps2_data_low == 1'b1) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) checkOutput("device_request_seen", 0, 1);
    cap_bits = '0;
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11 && ack) dev_data_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b1;
      k = 0;
      if (meas && e == 1) begin
        while (ps2_data_low && k < HALF) begin
          tick();
          k++;
        end
        checkOutput("edge_to_data_update", k, 5);
      end else if (meas && e == 11 && !ack) begin
        while (!tx_error && k < HALF) begin
          tick();
          k++;
        end
        checkOutput("edge11_to_error", k, 5);
      end
      repeat (HALF - k) tick();
      cap_bits[e-1] = ps2_data;
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input bit poke);
    int k;
    k = 0;
    while (!tx_done && k < 200) begin
      tick();
      k++;
    end
    checkOutput("tx_done_seen", int'(tx_done), 1);
    if (poke) begin
      tx_data  = 8'h77;
      tx_start = 1'b1;
    end
    tick();
    tx_start = 1'b0;
    checkOutput("busy_after_done", int'(tx_busy), 0);
  endtask

  initial begin
    int k;
    fork
      forever begin
        @(negedge clk100);
        model_step();
      end
    join_none

    tick();
    chk_en = 1'b1;
    checkOutput("reset_busy", int'(tx_busy), 0);
    checkOutput("reset_lines", int'({ps2_clk_low, ps2_data_low}), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();

    $display("[TB] send 0xED with ack");
    applyStimulus(8'hED);
    device_frame(11, 1'b1, 1'b1);
    checkOutput("frame_0xED", int'(cap_bits[9:0]), 'h3ED);
    wait_done(1'b0);
    repeat (10) tick();

    $display("[TB] send 0x01 with ignored start of 0xAA mid-transfer");
    applyStimulus(8'h01);
    fork
      device_frame(11, 1'b1, 1'b0);
      begin
        repeat (6 * HALF) tick();
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
      end
    join
    checkOutput("frame_0x01", int'(cap_bits[9:0]), 'h201);
    wait_done(1'b0);
    repeat (10) tick();

    $display("[TB] no device");
    applyStimulus(8'h12);
    k = 0;
    while (!tx_error && k < T + 50) begin
      tick();
      k++;
    end
    checkOutput("timeout_cycles", k, T);
    checkOutput("timeout_lines", int'({ps2_clk_low, ps2_data_low}), 0);
    repeat (10) tick();

    $display("[TB] missing ack");
    applyStimulus(8'hA5);
    device_frame(11, 1'b0, 1'b1);
    checkOutput("noack_lines", int'({ps2_clk_low, ps2_data_low, tx_busy}), 0);
    repeat (10) tick();

    $display("[TB] reset after edge 5, then fresh 0x55");
    applyStimulus(8'hE0);
    device_frame(5, 1'b0, 1'b0);
    repeat (8) tick();
    checkOutput("pre_reset_data_low", int'(ps2_data_low), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset_mid_lines", int'({ps2_clk_low, ps2_data_low}), 0);
    checkOutput("reset_mid_flags", int'({tx_busy, tx_done, tx_error}), 0);
    repeat (10) tick();
    applyStimulus(8'h55);
    device_frame(11, 1'b1, 1'b0);
    checkOutput("frame_0x55", int'(cap_bits[9:0]), 'h355);
    wait_done(1'b1);
    repeat (20) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
